// File: rtl/alu_resp_pipe.sv
// Two-stage ALU responder: capture stage, then decode/compute/result stage with an illegal-command counter.
// Optional macro ALU_ACC_EN turns A-table opcode 7 into an accumulate into the registered result c.
module alu_resp_pipe #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ALU_en,
  input  logic                 a_en,
  input  logic                 b_en,
  input  logic [2:0]           a_op,
  input  logic [1:0]           b_op,
  input  logic signed [4:0]    A,
  input  logic signed [4:0]    B,
  output logic signed [5:0]    c,
  output logic                 c_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                vld_p1;
  logic                a_en_p1;
  logic                b_en_p1;
  logic [2:0]          a_op_p1;
  logic [1:0]          b_op_p1;
  logic signed [4:0]   a_p1;
  logic signed [4:0]   b_p1;

  logic                nop;
  logic                legal;
  logic signed [5:0]   res;
  logic                retire_ok;
  logic                retire_bad;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Returns {legal, result}; operands arrive already sign-extended to 6 bits.
  function automatic logic [6:0] compute(
    input logic              ae,
    input logic              be,
    input logic [2:0]        aop,
    input logic [1:0]        bop,
    input logic signed [5:0] a6,
    input logic signed [5:0] b6,
    input logic signed [5:0] cur
  );
    logic              ok;
    logic signed [5:0] r;
    ok = 1'b1;
    r  = '0;
    if (ae && !be) begin
      case (aop)
        3'd0: r = a6 + b6;
        3'd1: r = a6 - b6;
        3'd2: r = a6 ^ b6;
        3'd3: r = a6 & b6;
        3'd4: r = a6 | b6;
        3'd5: r = ~(a6 ^ b6);
        3'd6: r = a6;
        default: begin
`ifdef ALU_ACC_EN
          r = cur + a6;
`else
          r  = cur;
          ok = 1'b0;
`endif
        end
      endcase
    end else if (!ae && be) begin
      case (bop)
        2'd0: r = ~(a6 & b6);
        2'd1: r = b6 - a6;
        2'd2: r = b6;
        default: r = -a6;
      endcase
    end else begin
      ok = 1'b0;
    end
    return {ok, r};
  endfunction

  // ---- stage 1: capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= ALU_en;
  end

  always_ff @(posedge clk) begin
    if (ALU_en) begin
      a_p1    <= A;
      b_p1    <= B;
      a_en_p1 <= a_en;
      b_en_p1 <= b_en;
      a_op_p1 <= a_op;
      b_op_p1 <= b_op;
    end
  end

  // ---- stage 2: decode, compute, retire ----
  always_comb begin
    nop          = !a_en_p1 && !b_en_p1;
    {legal, res} = compute(a_en_p1, b_en_p1, a_op_p1, b_op_p1,
                           {a_p1[4], a_p1}, {b_p1[4], b_p1}, c);
    retire_ok    = vld_p1 && !nop && legal;
    retire_bad   = vld_p1 && !nop && !legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c       <= '0;
      c_valid <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      c_valid <= retire_ok;
      err     <= retire_bad;
      if (retire_ok)  c       <= res;
      if (retire_bad) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_alu_resp_pipe.sv
// Self-checking bench for alu_resp_pipe: directed vector table, hand-written pipeline sequences and
// randomized commands against a behavioural model. Honours ALU_ACC_EN the same way the design does.
module tb_alu_resp_pipe;

  logic              clk;
  logic              rst;
  logic              ALU_en;
  logic              a_en;
  logic              b_en;
  logic [2:0]        a_op;
  logic [1:0]        b_op;
  logic signed [4:0] A;
  logic signed [4:0] B;
  logic signed [5:0] c;
  logic              c_valid;
  logic              err;
  logic [7:0]        err_cnt;

  alu_resp_pipe #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ALU_en(ALU_en), .a_en(a_en), .b_en(b_en),
    .a_op(a_op), .b_op(b_op), .A(A), .B(B),
    .c(c), .c_valid(c_valid), .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit       ae;
    bit       be;
    bit [2:0] aop;
    bit [1:0] bop;
    int       a;
    int       b;
  } cmd_t;

  typedef struct {
    cmd_t cmd;
    bit   vld;
    bit   er;
    int   cv;
    int   cnt;
  } vec_t;

  int   tests;
  int   fails;
  int   exp_c;
  bit   exp_valid;
  bit   exp_err;
  int   exp_cnt;
  cmd_t pend[$];
  cmd_t idle;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wrap6(input int v);
    int m;
    m = ((v % 64) + 64) % 64;
    return (m >= 32) ? m - 64 : m;
  endfunction

  function automatic cmd_t mk(input bit ae, input bit be, input int aop, input int bop,
                              input int a, input int b);
    cmd_t x;
    x.en  = 1'b1;
    x.ae  = ae;
    x.be  = be;
    x.aop = aop[2:0];
    x.bop = bop[1:0];
    x.a   = a;
    x.b   = b;
    return x;
  endfunction

  // Behavioural meaning of one retired command.
  task automatic retire(input cmd_t x);
    int r;
    bit ok;
    ok = 1'b1;
    r  = 0;
    if (!x.ae && !x.be) return;
    if (x.ae && x.be) ok = 1'b0;
    else if (x.ae) begin
      case (x.aop)
        0: r = x.a + x.b;
        1: r = x.a - x.b;
        2: r = x.a ^ x.b;
        3: r = x.a & x.b;
        4: r = x.a | x.b;
        5: r = ~(x.a ^ x.b);
        6: r = x.a;
        default: begin
`ifdef ALU_ACC_EN
          r = wrap6(exp_c + x.a);
`else
          ok = 1'b0;
`endif
        end
      endcase
    end else begin
      case (x.bop)
        0: r = ~(x.a & x.b);
        1: r = x.b - x.a;
        2: r = x.b;
        default: r = -x.a;
      endcase
    end
    if (ok) begin
      exp_c     = r;
      exp_valid = 1'b1;
    end else begin
      exp_err = 1'b1;
      if (exp_cnt < 255) exp_cnt++;
    end
  endtask

  task automatic model_reset();
    exp_c = 0; exp_valid = 0; exp_err = 0; exp_cnt = 0;
    pend.delete();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".c"},       int'(c),       exp_c);
    check({tag, ".c_valid"}, int'(c_valid), int'(exp_valid));
    check({tag, ".err"},     int'(err),     int'(exp_err));
    check({tag, ".err_cnt"}, int'(err_cnt), exp_cnt);
  endtask

  // Called 1 time unit after a posedge: drive x, advance one edge, update model, compare.
  task automatic drive(input cmd_t x, input string tag);
    ALU_en = x.en;
    a_en   = x.ae;
    b_en   = x.be;
    a_op   = x.aop;
    b_op   = x.bop;
    A      = x.a[4:0];
    B      = x.b[4:0];
    @(posedge clk);
    #1;
    exp_valid = 0;
    exp_err   = 0;
    if (pend.size() > 0) retire(pend.pop_front());
    if (x.en) pend.push_back(x);
    check_model(tag);
  endtask

  vec_t vt[10];
  int   seq_exp[4];
  cmd_t r;

  initial begin
    tests = 0;
    fails = 0;
    idle  = '{en: 1'b0, ae: 1'b0, be: 1'b0, aop: 3'd0, bop: 2'd0, a: 0, b: 0};

    vt[0] = '{mk(1, 0, 0, 0,  15, 15), 1, 0,  30, 0};
    vt[1] = '{mk(1, 0, 1, 0, -16, 15), 1, 0, -31, 0};
    vt[2] = '{mk(0, 1, 0, 3, -16,  0), 1, 0,  16, 0};
    vt[3] = '{mk(0, 1, 0, 0,   5,  3), 1, 0,  -2, 0};
    vt[4] = '{mk(1, 1, 0, 0,   7,  7), 0, 1,  -2, 1};
    vt[5] = '{mk(0, 0, 0, 0,   9,  9), 0, 0,  -2, 1};
    vt[6] = '{mk(1, 0, 2, 0,   5,  3), 1, 0,   6, 1};
    vt[7] = '{mk(1, 0, 5, 0,   5,  3), 1, 0,  -7, 1};
    vt[8] = '{mk(0, 1, 0, 1,   3, -4), 1, 0,  -7, 1};
    vt[9] = '{mk(1, 0, 6, 0,  -9, 11), 1, 0,  -9, 1};

    rst = 1'b1;
    ALU_en = 0; a_en = 0; b_en = 0; a_op = 0; b_op = 0; A = 0; B = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    // directed table: command, one idle edge, then compare against constants
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].cmd, "tbl_issue");
      drive(idle, "tbl_retire");
      check($sformatf("vec%0d.c", i),       int'(c),       vt[i].cv);
      check($sformatf("vec%0d.c_valid", i), int'(c_valid), int'(vt[i].vld));
      check($sformatf("vec%0d.err", i),     int'(err),     int'(vt[i].er));
      check($sformatf("vec%0d.err_cnt", i), int'(err_cnt), vt[i].cnt);
    end

    // back-to-back adds with ALU_en held high
    for (int k = 1; k <= 4; k++) begin
      drive(mk(1, 0, 0, 0, k, k), "b2b");
      if (k > 1) begin
        check($sformatf("b2b%0d.c", k - 1),       int'(c),       2 * (k - 1));
        check($sformatf("b2b%0d.c_valid", k - 1), int'(c_valid), 1);
      end
    end
    drive(idle, "b2b_tail");
    check("b2b4.c", int'(c), 8);
    check("b2b4.c_valid", int'(c_valid), 1);
    drive(idle, "b2b_drain");
    check("b2b.valid_drops", int'(c_valid), 0);

    // opcode 7 issued four times from c=0
    drive(mk(1, 0, 6, 0, 0, 0), "acc_clear");
    drive(idle, "acc_clear2");
    check("acc.start_c", int'(c), 0);
`ifdef ALU_ACC_EN
    seq_exp = '{10, 20, 30, -24};
`else
    seq_exp = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++) begin
      drive((k < 4) ? mk(1, 0, 7, 0, 10, 0) : idle, "acc");
      if (k > 0) begin
        check($sformatf("acc%0d.c", k), int'(c), seq_exp[k - 1]);
`ifdef ALU_ACC_EN
        check($sformatf("acc%0d.c_valid", k), int'(c_valid), 1);
`else
        check($sformatf("acc%0d.err", k), int'(err), 1);
`endif
      end
    end
    drive(idle, "acc_drain");

    // randomized commands against the model
    for (int n = 0; n < 300; n++) begin
      r.en  = ($urandom_range(3, 0) != 0);
      r.ae  = $urandom_range(1, 0);
      r.be  = $urandom_range(1, 0);
      r.aop = 3'($urandom_range(7, 0));
      r.bop = 2'($urandom_range(3, 0));
      r.a   = int'($urandom_range(31, 0)) - 16;
      r.b   = int'($urandom_range(31, 0)) - 16;
      drive(r, "rand");
    end
    drive(idle, "rand_drain");

    // counter saturation
    for (int n = 0; n < 300; n++) drive(mk(1, 1, 0, 0, 1, 1), "sat");
    drive(idle, "sat_drain");
    check("sat.err_cnt", int'(err_cnt), 255);

    // mid-stream reset with two commands in flight
    drive(mk(1, 0, 0, 0, 3, 4), "mid_a");
    ALU_en = 1; a_en = 1; b_en = 1; a_op = 0; b_op = 0; A = 1; B = 1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("midrst");
    @(posedge clk);
    #1;
    ALU_en = 0;
    check_model("midrst_hold");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) drive(idle, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 500000);
    $fatal(1);
  end

endmodule
